// File: rtl/slow_clock_monitor.sv
// Measures the period of an asynchronous slow square wave in clk cycles,
// declares lock once the period is stable, and flags loss of edges.
module slow_clock_monitor #(
    parameter int CNT_W      = 16,
    parameter int TIMEOUT    = 1000,
    parameter int TOL        = 0,
    parameter int LOCK_COUNT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             slow_in,
    output logic             edge_pulse,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);

    localparam int MCW = $clog2(LOCK_COUNT + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t           state;
    logic             s1, s2, s3;
    logic [CNT_W-1:0] counter;
    logic [MCW-1:0]   match_cnt;
    logic             have_prev;

    logic             rise;
    logic [CNT_W:0]   new_per;
    logic [CNT_W:0]   old_per;
    logic [CNT_W:0]   diff;
    logic             match;
    logic             at_limit;
    logic [MCW-1:0]   match_inc;

    // One extra bit keeps counter+1 and the difference free of wrap-around
    always_comb begin
        rise      = s2 & ~s3;
        new_per   = {1'b0, counter} + {{CNT_W{1'b0}}, 1'b1};
        old_per   = {1'b0, period};
        diff      = (new_per >= old_per) ? (new_per - old_per)
                                         : (old_per - new_per);
        match     = have_prev && (diff <= (CNT_W+1)'(TOL));
        at_limit  = (counter == CNT_W'(TIMEOUT - 1));
        match_inc = (match_cnt == MCW'(LOCK_COUNT)) ? match_cnt
                                                    : match_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1           <= 1'b0;
            s2           <= 1'b0;
            s3           <= 1'b0;
            counter      <= '0;
            match_cnt    <= '0;
            have_prev    <= 1'b0;
            period       <= '0;
            edge_pulse   <= 1'b0;
            period_valid <= 1'b0;
            locked       <= 1'b0;
            timeout      <= 1'b0;
            state        <= IDLE;
        end else begin
            s1           <= slow_in;
            s2           <= s1;
            s3           <= s2;
            edge_pulse   <= rise;
            period_valid <= 1'b0;
            timeout      <= 1'b0;
            case (state)
                IDLE: begin
                    counter   <= '0;
                    match_cnt <= '0;
                    have_prev <= 1'b0;
                    locked    <= 1'b0;
                    if (rise) state <= MEASURE;
                end
                default: begin
                    if (rise) begin
                        period       <= new_per[CNT_W-1:0];
                        period_valid <= 1'b1;
                        counter      <= '0;
                        have_prev    <= 1'b1;
                        if (match) begin
                            match_cnt <= match_inc;
                            if (match_inc == MCW'(LOCK_COUNT)) begin
                                state  <= LOCKED;
                                locked <= 1'b1;
                            end
                        end else begin
                            match_cnt <= '0;
                            state     <= MEASURE;
                            locked    <= 1'b0;
                        end
                    end else if (at_limit) begin
                        timeout   <= 1'b1;
                        state     <= IDLE;
                        counter   <= '0;
                        match_cnt <= '0;
                        have_prev <= 1'b0;
                        locked    <= 1'b0;
                    end else if (counter != '1) begin
                        counter <= counter + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
